// File: rtl/lv_pwm_code_decode.sv
// rtl/lv_pwm_code_decode.sv - multi-channel pulse-coded interrupt line decoder
module lv_pwm_code_decode #(
  parameter int CH_NUM        = 2,
  parameter int DEB_CYC       = 4,
  parameter int GAP_CYC       = 12,
  parameter int MAX_EDGE      = 7,
  parameter int CODE_W        = $clog2(MAX_EDGE + 1),
  parameter int ASSERT_CODE   = 1,
  parameter int DEASSERT_CODE = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [CH_NUM-1:0]          i_pwm_n,
  input  logic [CH_NUM-1:0]          i_ch_en,
  output logic [CH_NUM-1:0]          o_flt,
  output logic [CH_NUM-1:0]          o_code_vld,
  output logic [CH_NUM*CODE_W-1:0]   o_code,
  output logic [CH_NUM-1:0]          o_err,
  output logic [CH_NUM-1:0]          o_intb_n
);

  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC);

  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [CODE_W-1:0] MAX_E    = CODE_W'(MAX_EDGE);
  localparam logic [CODE_W-1:0] A_CODE   = CODE_W'(ASSERT_CODE);
  localparam logic [CODE_W-1:0] D_CODE   = CODE_W'(DEASSERT_CODE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    OVF   = 2'd2
  } state_t;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic              sync1_q, sync2_q;
    logic              flt_q, flt_d, flt_dly_q;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              edge_w;
    state_t            state_q;
    logic [CODE_W-1:0] edge_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic              vld_q, err_q, intb_q;
    logic [CODE_W-1:0] code_q;

    // Debounce: the filtered level follows the synced line only after it has differed long enough
    always_comb begin
      flt_d     = flt_q;
      deb_cnt_d = '0;
      if (sync2_q != flt_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          flt_d     = sync2_q;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
    end

    // Synchroniser, filter state and one-cycle-delayed filtered level for edge detection
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        sync1_q   <= 1'b1;
        sync2_q   <= 1'b1;
        flt_q     <= 1'b1;
        flt_dly_q <= 1'b1;
        deb_cnt_q <= '0;
      end else begin
        sync1_q   <= i_pwm_n[c];
        sync2_q   <= sync1_q;
        flt_q     <= flt_d;
        flt_dly_q <= flt_q;
        deb_cnt_q <= deb_cnt_d;
      end
    end

    // Both directions count; the pulse is derived from registers so it cannot be missed
    assign edge_w = flt_q ^ flt_dly_q;

    // Burst FSM: count edges, close the burst after an idle gap, emit code or overflow strobe
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        state_q    <= IDLE;
        edge_cnt_q <= '0;
        gap_cnt_q  <= '0;
        vld_q      <= 1'b0;
        err_q      <= 1'b0;
        code_q     <= '0;
        intb_q     <= 1'b1;
      end else begin
        vld_q <= 1'b0;
        err_q <= 1'b0;
        if (!i_ch_en[c]) begin
          state_q    <= IDLE;
          edge_cnt_q <= '0;
          gap_cnt_q  <= '0;
        end else begin
          case (state_q)
            IDLE: begin
              if (edge_w) begin
                state_q    <= COUNT;
                edge_cnt_q <= CODE_W'(1);
                gap_cnt_q  <= '0;
              end
            end
            COUNT: begin
              // An edge in the timeout cycle extends the burst rather than closing it
              if (edge_w) begin
                gap_cnt_q <= '0;
                if (edge_cnt_q == MAX_E) begin
                  state_q <= OVF;
                end else begin
                  edge_cnt_q <= edge_cnt_q + CODE_W'(1);
                end
              end else if (gap_cnt_q == GAP_LAST) begin
                vld_q  <= 1'b1;
                code_q <= edge_cnt_q;
                if (edge_cnt_q == A_CODE) begin
                  intb_q <= 1'b0;
                end else if (edge_cnt_q == D_CODE) begin
                  intb_q <= 1'b1;
                end
                state_q    <= IDLE;
                edge_cnt_q <= '0;
                gap_cnt_q  <= '0;
              end else begin
                gap_cnt_q <= gap_cnt_q + GAP_W'(1);
              end
            end
            OVF: begin
              if (edge_w) begin
                gap_cnt_q <= '0;
              end else if (gap_cnt_q == GAP_LAST) begin
                err_q      <= 1'b1;
                state_q    <= IDLE;
                edge_cnt_q <= '0;
                gap_cnt_q  <= '0;
              end else begin
                gap_cnt_q <= gap_cnt_q + GAP_W'(1);
              end
            end
            default: begin
              state_q    <= IDLE;
              edge_cnt_q <= '0;
              gap_cnt_q  <= '0;
            end
          endcase
        end
      end
    end

    assign o_flt[c]                    = flt_q;
    assign o_code_vld[c]               = vld_q;
    assign o_err[c]                    = err_q;
    assign o_intb_n[c]                 = intb_q;
    assign o_code[c*CODE_W +: CODE_W]  = code_q;
  end

endmodule

// File: tb/tb_lv_pwm_code_decode.sv
// tb/tb_lv_pwm_code_decode.sv - directed self-checking bench for lv_pwm_code_decode
module tb_lv_pwm_code_decode;

  logic       clk;
  logic       rst;
  logic [1:0] pwm;
  logic [1:0] en;
  logic [1:0] flt, vld, err, intb;
  logic [5:0] code;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int vld_cnt [2];
  int err_cnt [2];
  int vld_cyc [2];
  int err_cyc [2];
  int chg_cyc [2];
  int flt0_low = 0;
  logic [1:0] flt_prev = 2'b11;

  lv_pwm_code_decode dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_pwm_n    (pwm),
    .i_ch_en    (en),
    .o_flt      (flt),
    .o_code_vld (vld),
    .o_code     (code),
    .o_err      (err),
    .o_intb_n   (intb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observes strobes and filtered-level changes mid-cycle
  initial begin
    for (int c = 0; c < 2; c++) begin
      vld_cnt[c] = 0; err_cnt[c] = 0; vld_cyc[c] = 0; err_cyc[c] = 0; chg_cyc[c] = 0;
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (vld[c] === 1'b1) begin vld_cnt[c]++; vld_cyc[c] = cyc; end
      if (err[c] === 1'b1) begin err_cnt[c]++; err_cyc[c] = cyc; end
      if (flt[c] !== flt_prev[c]) chg_cyc[c] = cyc;
      flt_prev[c] = flt[c];
    end
    if (flt[0] === 1'b0) flt0_low++;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    pwm = 2'b11;
    cyc_wait(10);
    rst = 1'b1;
    cyc_wait(2);
    rst = 1'b0;
    cyc_wait(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc_wait(3);
    tests++; if (flt !== 2'b11) begin fails++; $display("FAIL reset_flt got %b expected 11", flt); end
    tests++; if (vld !== 2'b00) begin fails++; $display("FAIL reset_vld got %b expected 00", vld); end
    tests++; if (code !== 6'd0) begin fails++; $display("FAIL reset_code got %h expected 0", code); end
    tests++; if (err !== 2'b00) begin fails++; $display("FAIL reset_err got %b expected 00", err); end
    tests++; if (intb !== 2'b11) begin fails++; $display("FAIL reset_intb got %b expected 11", intb); end
    rst = 1'b0;
    cyc_wait(3);
  endtask

  task automatic test_single_pulse();
    int bv0, bv1, be0;
    bv0 = vld_cnt[0]; bv1 = vld_cnt[1]; be0 = err_cnt[0];
    pwm[0] = 1'b0; cyc_wait(8);
    pwm[0] = 1'b1; cyc_wait(40);
    tests++; if (vld_cnt[0] - bv0 !== 1) begin fails++; $display("FAIL pulse_vld_cnt got %0d expected 1", vld_cnt[0] - bv0); end
    tests++; if (code[2:0] !== 3'd2) begin fails++; $display("FAIL pulse_code got %0d expected 2", code[2:0]); end
    tests++; if (intb[0] !== 1'b1) begin fails++; $display("FAIL pulse_intb got %b expected 1", intb[0]); end
    tests++; if (err_cnt[0] - be0 !== 0) begin fails++; $display("FAIL pulse_err got %0d expected 0", err_cnt[0] - be0); end
    tests++; if (vld_cnt[1] - bv1 !== 0) begin fails++; $display("FAIL pulse_ch1_quiet got %0d expected 0", vld_cnt[1] - bv1); end
  endtask

  task automatic test_one_edge();
    int bv0;
    bv0 = vld_cnt[0];
    pwm[0] = 1'b0; cyc_wait(40);
    tests++; if (vld_cnt[0] - bv0 !== 1) begin fails++; $display("FAIL one_vld_cnt got %0d expected 1", vld_cnt[0] - bv0); end
    tests++; if (code[2:0] !== 3'd1) begin fails++; $display("FAIL one_code got %0d expected 1", code[2:0]); end
    tests++; if (intb[0] !== 1'b0) begin fails++; $display("FAIL one_intb got %b expected 0", intb[0]); end
    tests++; if (vld_cyc[0] - chg_cyc[0] !== 13) begin fails++; $display("FAIL one_latency got %0d expected 13", vld_cyc[0] - chg_cyc[0]); end
  endtask

  task automatic test_assert_deassert();
    int bv0;
    do_reset();
    bv0 = vld_cnt[0];
    pwm[0] = 1'b0; cyc_wait(40);
    tests++; if (vld_cnt[0] - bv0 !== 1) begin fails++; $display("FAIL ad_first_cnt got %0d expected 1", vld_cnt[0] - bv0); end
    tests++; if (code[2:0] !== 3'd1) begin fails++; $display("FAIL ad_first_code got %0d expected 1", code[2:0]); end
    tests++; if (intb[0] !== 1'b0) begin fails++; $display("FAIL ad_assert got %b expected 0", intb[0]); end
    bv0 = vld_cnt[0];
    pwm[0] = 1'b1; cyc_wait(6);
    pwm[0] = 1'b0; cyc_wait(6);
    pwm[0] = 1'b1; cyc_wait(40);
    tests++; if (vld_cnt[0] - bv0 !== 1) begin fails++; $display("FAIL ad_second_cnt got %0d expected 1", vld_cnt[0] - bv0); end
    tests++; if (code[2:0] !== 3'd3) begin fails++; $display("FAIL ad_second_code got %0d expected 3", code[2:0]); end
    tests++; if (intb[0] !== 1'b1) begin fails++; $display("FAIL ad_deassert got %b expected 1", intb[0]); end
  endtask

  task automatic test_glitch();
    int bv0, be0, bl;
    bv0 = vld_cnt[0]; be0 = err_cnt[0]; bl = flt0_low;
    repeat (5) begin
      pwm[0] = 1'b0; cyc_wait(3);
      pwm[0] = 1'b1; cyc_wait(17);
    end
    cyc_wait(20);
    tests++; if (flt0_low - bl !== 0) begin fails++; $display("FAIL glitch_flt got %0d low cycles expected 0", flt0_low - bl); end
    tests++; if (vld_cnt[0] - bv0 !== 0) begin fails++; $display("FAIL glitch_vld got %0d expected 0", vld_cnt[0] - bv0); end
    tests++; if (err_cnt[0] - be0 !== 0) begin fails++; $display("FAIL glitch_err got %0d expected 0", err_cnt[0] - be0); end
  endtask

  task automatic test_overflow();
    int bv0, be0;
    bv0 = vld_cnt[0]; be0 = err_cnt[0];
    repeat (9) begin
      pwm[0] = ~pwm[0]; cyc_wait(6);
    end
    cyc_wait(40);
    tests++; if (err_cnt[0] - be0 !== 1) begin fails++; $display("FAIL ovf_err_cnt got %0d expected 1", err_cnt[0] - be0); end
    tests++; if (vld_cnt[0] - bv0 !== 0) begin fails++; $display("FAIL ovf_vld got %0d expected 0", vld_cnt[0] - bv0); end
    tests++; if (intb[0] !== 1'b1) begin fails++; $display("FAIL ovf_intb got %b expected 1", intb[0]); end
    tests++; if (err_cyc[0] - chg_cyc[0] !== 13) begin fails++; $display("FAIL ovf_latency got %0d expected 13", err_cyc[0] - chg_cyc[0]); end
  endtask

  task automatic test_multi_channel();
    int bv0, bv1;
    do_reset();
    bv0 = vld_cnt[0]; bv1 = vld_cnt[1];
    pwm[0] = 1'b0; cyc_wait(2);
    pwm[1] = 1'b0; cyc_wait(6);
    pwm[1] = 1'b1; cyc_wait(6);
    pwm[1] = 1'b0; cyc_wait(40);
    tests++; if (vld_cnt[0] - bv0 !== 1) begin fails++; $display("FAIL mc_ch0_cnt got %0d expected 1", vld_cnt[0] - bv0); end
    tests++; if (vld_cnt[1] - bv1 !== 1) begin fails++; $display("FAIL mc_ch1_cnt got %0d expected 1", vld_cnt[1] - bv1); end
    tests++; if (code[2:0] !== 3'd1) begin fails++; $display("FAIL mc_ch0_code got %0d expected 1", code[2:0]); end
    tests++; if (code[5:3] !== 3'd3) begin fails++; $display("FAIL mc_ch1_code got %0d expected 3", code[5:3]); end
    tests++; if (intb !== 2'b10) begin fails++; $display("FAIL mc_intb got %b expected 10", intb); end
    tests++; if (vld_cyc[0] - chg_cyc[0] !== 13) begin fails++; $display("FAIL mc_ch0_latency got %0d expected 13", vld_cyc[0] - chg_cyc[0]); end
    tests++; if (vld_cyc[1] - chg_cyc[1] !== 13) begin fails++; $display("FAIL mc_ch1_latency got %0d expected 13", vld_cyc[1] - chg_cyc[1]); end
  endtask

  task automatic test_disable();
    int bv1, be1;
    bv1 = vld_cnt[1]; be1 = err_cnt[1];
    pwm[1] = 1'b1; cyc_wait(6);
    pwm[1] = 1'b0; cyc_wait(3);
    en[1] = 1'b0; cyc_wait(40);
    tests++; if (vld_cnt[1] - bv1 !== 0) begin fails++; $display("FAIL dis_vld got %0d expected 0", vld_cnt[1] - bv1); end
    tests++; if (err_cnt[1] - be1 !== 0) begin fails++; $display("FAIL dis_err got %0d expected 0", err_cnt[1] - be1); end
    tests++; if (code[5:3] !== 3'd3) begin fails++; $display("FAIL dis_code_hold got %0d expected 3", code[5:3]); end
    tests++; if (intb[1] !== 1'b1) begin fails++; $display("FAIL dis_intb_hold got %b expected 1", intb[1]); end
    tests++; if (flt[1] !== 1'b0) begin fails++; $display("FAIL dis_flt_track got %b expected 0", flt[1]); end
    en[1] = 1'b1; cyc_wait(20);
    tests++; if (vld_cnt[1] - bv1 !== 0) begin fails++; $display("FAIL dis_reenable_vld got %0d expected 0", vld_cnt[1] - bv1); end
  endtask

  task automatic test_reset_mid_burst();
    int bv0;
    pwm = 2'b11; cyc_wait(40);
    pwm[0] = 1'b0; cyc_wait(6);
    pwm[0] = 1'b1; cyc_wait(8);
    rst = 1'b1; cyc_wait(1);
    tests++; if (flt !== 2'b11) begin fails++; $display("FAIL rmb_flt got %b expected 11", flt); end
    tests++; if (vld !== 2'b00) begin fails++; $display("FAIL rmb_vld got %b expected 00", vld); end
    tests++; if (code !== 6'd0) begin fails++; $display("FAIL rmb_code got %h expected 0", code); end
    tests++; if (err !== 2'b00) begin fails++; $display("FAIL rmb_err got %b expected 00", err); end
    tests++; if (intb !== 2'b11) begin fails++; $display("FAIL rmb_intb got %b expected 11", intb); end
    rst = 1'b0; cyc_wait(2);
    bv0 = vld_cnt[0];
    pwm[0] = 1'b0; cyc_wait(6);
    pwm[0] = 1'b1; cyc_wait(40);
    tests++; if (vld_cnt[0] - bv0 !== 1) begin fails++; $display("FAIL rmb_post_cnt got %0d expected 1", vld_cnt[0] - bv0); end
    tests++; if (code[2:0] !== 3'd2) begin fails++; $display("FAIL rmb_post_code got %0d expected 2", code[2:0]); end
    tests++; if (intb[0] !== 1'b1) begin fails++; $display("FAIL rmb_post_intb got %b expected 1", intb[0]); end
  endtask

  initial begin
    rst = 1'b1;
    pwm = 2'b11;
    en  = 2'b11;
    test_reset();
    test_single_pulse();
    test_one_edge();
    test_assert_deassert();
    test_glitch();
    test_overflow();
    test_multi_channel();
    test_disable();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
